// File: rtl/lock_key_pkg.sv
// Shared constants and helpers for the combination-lock key-entry front end.
// Holds the 27 MHz default timings, the auto-repeat state encoding and the
// counter-width helper used to size the debounce and hold counters.
package lock_key_pkg;

    // Default timings for a 27 MHz board clock.
    localparam int DEB_CYC_27M  = 540000;    // 20 ms debounce window
    localparam int HOLD_CYC_27M = 27000000;  // 1 s press-to-first-repeat
    localparam int REP_CYC_27M  = 6750000;   // 250 ms repeat period

    // Per-key auto-repeat state encoding.
    localparam logic [1:0] REP_IDLE   = 2'd0;
    localparam logic [1:0] REP_HOLD   = 2'd1;
    localparam logic [1:0] REP_REPEAT = 2'd2;

    // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/key_deb_edge.sv
// One button input chain: 2-FF synchronizer, debounce counter, stable level
// and a one-cycle press pulse on a debounced 1->0 transition.
// The button is active-low; the stable level resets to 1 (released), so a
// button held through reset release is reported as a fresh press.
module key_deb_edge
    import lock_key_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_27M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic deb,
    output logic press
);

    localparam int              CW       = cnt_width(DEB_CYC);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_stable_d;
    logic [CW-1:0] r_cnt;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed for DEB_CYC consecutive cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b1;
        end else if (r_sync2 != r_stable) begin
            if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // One-cycle delayed copy of the stable level for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stable_d <= 1'b1;
        end else begin
            r_stable_d <= r_stable;
        end
    end

    assign deb   = r_stable;
    // Press = stable level just fell; releases produce nothing.
    assign press = r_stable_d & ~r_stable;

endmodule

// File: rtl/lock_key_entry.sv
// Key-entry front end for the combination lock: debounces NUM_KEYS digit keys
// plus enter and init, keeps one modulo-(DIGIT_MAX+1) digit per key and emits
// single-cycle press pulses for the downstream compare/FSM logic.
// Optional feature macro: LOCK_KEY_AUTOREPEAT_EN builds the per-key long-press
// auto-repeat (IDLE/HOLD/REPEAT) machines; without it each press counts once.
// Each per-key machine's state is visible as g_rep[i].r_state.
module lock_key_entry
    import lock_key_pkg::*;
#(
    parameter int NUM_KEYS  = 2,
    parameter int DIGIT_W   = 2,
    parameter int DIGIT_MAX = 3,
    parameter int DEB_CYC   = DEB_CYC_27M,
    parameter int HOLD_CYC  = HOLD_CYC_27M,
    parameter int REP_CYC   = REP_CYC_27M
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_KEYS-1:0]           key,
    input  logic                          enter,
    input  logic                          init,
    output logic                          enter_trig,
    output logic                          init_trig,
    output logic [NUM_KEYS-1:0]           key_trig,
    output logic [NUM_KEYS*DIGIT_W-1:0]   ctrl
);

    localparam int                 NUM_IN  = NUM_KEYS + 2;
    localparam logic [DIGIT_W-1:0] DIG_MAX = DIGIT_W'(DIGIT_MAX);
    localparam logic [DIGIT_W-1:0] DIG_ONE = DIGIT_W'(1);

    // Input bit order: digit keys first, then enter, then init.
    logic [NUM_IN-1:0]             w_raw;
    logic [NUM_IN-1:0]             w_deb;
    logic [NUM_IN-1:0]             w_press;
    logic [NUM_KEYS-1:0]           w_key_press;
    logic [NUM_KEYS-1:0]           w_tick;
    logic [NUM_KEYS-1:0]           w_inc;
    logic [NUM_KEYS*DIGIT_W-1:0]   w_ctrl_next;
    logic [NUM_KEYS*DIGIT_W-1:0]   r_ctrl;
    logic                          w_unused_deb;

    assign w_raw = {init, enter, key};

    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        key_deb_edge #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_n (w_raw[g]),
            .deb   (w_deb[g]),
            .press (w_press[g])
        );
    end

    assign w_key_press = w_press[NUM_KEYS-1:0];
    assign enter_trig  = w_press[NUM_KEYS];
    assign init_trig   = w_press[NUM_KEYS+1];

    // Enter/init stable levels are only needed as press pulses.
    assign w_unused_deb = ^w_deb;

`ifdef LOCK_KEY_AUTOREPEAT_EN
    localparam int                HOLD_W    = cnt_width((HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REP_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_rep
        logic [1:0]        r_state;
        logic [HOLD_W-1:0] r_hold_cnt;
        logic              w_held;

        assign w_held = ~w_deb[g];

        // A tick fires when the hold delay or a repeat period expires while the key is still down.
        assign w_tick[g] = w_held &
                           (((r_state == REP_HOLD)   && (r_hold_cnt == HOLD_LAST)) ||
                            ((r_state == REP_REPEAT) && (r_hold_cnt == REP_LAST)));

        // Long-press tracker: press arms HOLD, hold expiry enters REPEAT, release or init returns to IDLE.
        always_ff @(posedge clk) begin
            if (!rst_n || init_trig) begin
                r_state    <= REP_IDLE;
                r_hold_cnt <= '0;
            end else begin
                case (r_state)
                    REP_IDLE: begin
                        r_hold_cnt <= '0;
                        if (w_key_press[g]) begin
                            r_state <= REP_HOLD;
                        end
                    end
                    REP_HOLD: begin
                        if (!w_held) begin
                            r_state    <= REP_IDLE;
                            r_hold_cnt <= '0;
                        end else if (r_hold_cnt == HOLD_LAST) begin
                            r_state    <= REP_REPEAT;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                        end
                    end
                    REP_REPEAT: begin
                        if (!w_held) begin
                            r_state    <= REP_IDLE;
                            r_hold_cnt <= '0;
                        end else if (r_hold_cnt == REP_LAST) begin
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                        end
                    end
                    default: begin
                        r_state    <= REP_IDLE;
                        r_hold_cnt <= '0;
                    end
                endcase
            end
        end
    end
`else
    // Repeat timing has no meaning without auto-repeat; keep the parameters referenced.
    logic [31:0] w_unused_rep_cfg;
    assign w_unused_rep_cfg = 32'(HOLD_CYC) ^ 32'(REP_CYC);
    assign w_tick           = '0;
`endif

    // Init wins over any same-cycle increment, and that increment is dropped.
    assign w_inc    = (w_key_press | w_tick) & {NUM_KEYS{~init_trig}};
    assign key_trig = w_inc;

    // Next digit values: wrap at DIGIT_MAX, otherwise count up; keys are independent.
    always_comb begin
        w_ctrl_next = r_ctrl;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (w_inc[i]) begin
                if (r_ctrl[i*DIGIT_W +: DIGIT_W] == DIG_MAX) begin
                    w_ctrl_next[i*DIGIT_W +: DIGIT_W] = '0;
                end else begin
                    w_ctrl_next[i*DIGIT_W +: DIGIT_W] = r_ctrl[i*DIGIT_W +: DIGIT_W] + DIG_ONE;
                end
            end
        end
    end

    // Registered digit store; init clears all digits.
    always_ff @(posedge clk) begin
        if (!rst_n || init_trig) begin
            r_ctrl <= '0;
        end else begin
            r_ctrl <= w_ctrl_next;
        end
    end

    assign ctrl = r_ctrl;

endmodule
